// File: rtl/uart_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if
//
// Bundles the configuration, FIFO handshake and serial-line signals of the
// UART transmit sequencer so they travel as one port.
//
//   slave  : view taken by uart_tx_ctrl (consumes config/FIFO, drives line)
//   master : view taken by whatever supplies config and the FIFO
//
// Signals
//   en          transmit enable; new frames start only while high
//   baud_div    clock cycles per bit (0 behaves as 1)
//   parity_en   insert a parity bit after the data bits
//   parity_odd  1 = odd parity, 0 = even
//   two_stop    1 = two stop bits, 0 = one
//   txfe        transmit FIFO empty flag
//   fifo_data   FIFO head byte, valid while txfe = 0
//   shift       one-cycle pop strobe to the FIFO
//   tx          serial line, idle high
//   busy        sequencer is outside IDLE
//   tx_done     one-cycle pulse after the last stop bit of a frame
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
    parameter int DIV_WIDTH = 16
);
    logic                 en;
    logic [DIV_WIDTH-1:0] baud_div;
    logic                 parity_en;
    logic                 parity_odd;
    logic                 two_stop;
    logic                 txfe;
    logic [7:0]           fifo_data;
    logic                 shift;
    logic                 tx;
    logic                 busy;
    logic                 tx_done;

    modport slave (
        input  en,
        input  baud_div,
        input  parity_en,
        input  parity_odd,
        input  two_stop,
        input  txfe,
        input  fifo_data,
        output shift,
        output tx,
        output busy,
        output tx_done
    );

    modport master (
        output en,
        output baud_div,
        output parity_en,
        output parity_odd,
        output two_stop,
        output txfe,
        output fifo_data,
        input  shift,
        input  tx,
        input  busy,
        input  tx_done
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Transmit-side sequencer between tx_fifo and the serial pin. While enabled
// and the FIFO holds data it pops one byte per frame and serializes it as
// start bit, DATA_BITS data bits LSB-first, optional parity, one or two stop
// bits. Each bit lasts a programmable number of clock cycles.
//
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    uart_tx_ctrl_if.slave (config, FIFO handshake, tx/busy/tx_done)
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | line high, waiting for en && !txfe
//   LOAD     | one cycle: pop strobe, capture byte and frame config
//   START    | line low for one bit period
//   DATA     | line = shift register bit 0, DATA_BITS bit periods
//   PARITY   | line = parity of captured data, one bit period
//   STOP     | line high for one or two bit periods
//
// All outputs are decoded from registered state only, so nothing on the
// input side reaches an output combinationally.
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    localparam logic [3:0]           LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;

    // Frame registers, loaded only in LOAD so mid-frame config edits are inert
    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic                 r_two_stop;
    logic                 r_data_par;

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [3:0]           r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_tx_done;

    logic [DIV_WIDTH-1:0] w_div_eff;
    logic                 w_tick;
    logic                 w_last_stop;
    logic                 w_start_ok;
    logic                 w_frame_end;
    logic                 w_tx;

    // A divisor of 0 would never reach its terminal count; run it as 1
    assign w_div_eff   = (bus.baud_div == '0) ? DIV_ONE : bus.baud_div;

    // r_div is never 0 once loaded, so div-1 cannot wrap
    assign w_tick      = (r_cnt == (r_div - DIV_ONE));
    assign w_last_stop = !r_two_stop || r_stop_idx;
    assign w_start_ok  = bus.en && !bus.txfe;
    assign w_frame_end = (r_state == S_STOP) && w_tick && w_last_stop;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next_state = S_START;
            end
            S_START: begin
                if (w_tick) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && (r_bit_idx == LAST_BIT)) begin
                    w_next_state = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                // Chain straight into the next LOAD so back-to-back frames
                // have only the single LOAD cycle between them
                if (w_tick && w_last_stop) begin
                    w_next_state = w_start_ok ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_div      <= DIV_ONE;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_two_stop <= 1'b0;
            r_data_par <= 1'b0;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shreg    <= '0;
            r_tx_done  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_tx_done <= w_frame_end;

            case (r_state)
                S_LOAD: begin
                    r_shreg    <= bus.fifo_data[DATA_BITS-1:0];
                    r_data_par <= ^bus.fifo_data[DATA_BITS-1:0];
                    r_div      <= w_div_eff;
                    r_par_en   <= bus.parity_en;
                    r_par_odd  <= bus.parity_odd;
                    r_two_stop <= bus.two_stop;
                    r_cnt      <= '0;
                    r_bit_idx  <= '0;
                    r_stop_idx <= 1'b0;
                end
                S_START, S_DATA, S_PARITY, S_STOP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + DIV_ONE;
                    end

                    if ((r_state == S_DATA) && w_tick) begin
                        r_shreg   <= r_shreg >> 1;
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end

                    if ((r_state == S_STOP) && w_tick) begin
                        r_stop_idx <= 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_START:  w_tx = 1'b0;
            S_DATA:   w_tx = r_shreg[0];
            S_PARITY: w_tx = r_data_par ^ r_par_odd;
            default:  w_tx = 1'b1;
        endcase
    end

    assign bus.tx      = w_tx;
    assign bus.shift   = (r_state == S_LOAD);
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    typedef struct packed {
        logic tx;
        logic shift;
        logic busy;
        logic done;
    } smp_t;

    logic clk;
    logic reset;

    uart_tx_ctrl_if #(.DIV_WIDTH(16)) bus ();

    uart_tx_ctrl #(
        .DATA_BITS (8),
        .DIV_WIDTH (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple FIFO model: bench pushes, DUT pops on shift
    logic [7:0] fifo_mem [0:15];
    logic [3:0] fifo_wr;
    logic [3:0] fifo_rd;

    assign bus.txfe      = (fifo_rd == fifo_wr);
    assign bus.fifo_data = fifo_mem[fifo_rd];

    initial fifo_rd = 4'd0;
    always @(posedge clk) begin
        if (bus.shift && (fifo_rd != fifo_wr)) fifo_rd <= fifo_rd + 4'd1;
    end

    // Per-cycle history sampled on the falling edge
    smp_t hist [0:8191];
    int   cyc_n      = 0;
    int   shift_cnt  = 0;
    int   done_cnt   = 0;
    int   empty_pops = 0;

    always @(negedge clk) begin
        if (cyc_n < 8192) hist[cyc_n] = {bus.tx, bus.shift, bus.busy, bus.tx_done};
        cyc_n = cyc_n + 1;
        if (bus.shift === 1'b1) shift_cnt = shift_cnt + 1;
        if (bus.tx_done === 1'b1) done_cnt = done_cnt + 1;
        if ((bus.shift === 1'b1) && (bus.txfe === 1'b1)) empty_pops = empty_pops + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        fifo_mem[fifo_wr] = d;
        fifo_wr = fifo_wr + 4'd1;
    endtask

    task automatic wait_shift(input string tag, input int max, output int idx);
        bit found;
        found = 1'b0;
        idx   = cyc_n;
        for (int i = 0; i < max; i++) begin
            step(1);
            if (hist[cyc_n-1].shift === 1'b1) begin
                idx   = cyc_n - 1;
                found = 1'b1;
                break;
            end
        end
        if (!found) chk({tag, "_shift_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_frame(input string tag, input int L, input logic [7:0] d,
                               input int div, input bit pe, input bit po, input bit ts);
        logic b [0:11];
        int   de, nb, len, guard;
        de = (div == 0) ? 1 : div;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1+i] = d[i];
        nb = 9;
        if (pe) begin
            b[nb] = (^d) ^ po;
            nb = nb + 1;
        end
        b[nb] = 1'b1;
        nb = nb + 1;
        if (ts) begin
            b[nb] = 1'b1;
            nb = nb + 1;
        end
        len = nb * de;
        guard = 0;
        while ((cyc_n <= L + len + 1) && (guard < 3000)) begin
            step(1);
            guard++;
        end
        if (cyc_n <= L + len + 1) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_load_shift"}, hist[L].shift, 1);
        chk({tag, "_load_busy"},  hist[L].busy,  1);
        chk({tag, "_load_tx"},    hist[L].tx,    1);
        for (int j = 1; j <= len; j++) begin
            chk($sformatf("%s_tx[%0d]", tag, j),    hist[L+j].tx,    b[(j-1)/de]);
            chk($sformatf("%s_shift[%0d]", tag, j), hist[L+j].shift, 0);
            chk($sformatf("%s_busy[%0d]", tag, j),  hist[L+j].busy,  1);
            chk($sformatf("%s_done[%0d]", tag, j),  hist[L+j].done,  0);
        end
        chk({tag, "_done_pulse"}, hist[L+len+1].done, 1);
        chk({tag, "_after_tx"},   hist[L+len+1].tx,   1);
    endtask

    function automatic int count_field(input int from, input int to, input int sel);
        int c;
        c = 0;
        for (int i = from; i < to; i++) begin
            case (sel)
                0: if (hist[i].shift === 1'b1) c++;
                1: if (hist[i].busy === 1'b1) c++;
                default: if (hist[i].tx !== 1'b1) c++;
            endcase
        end
        return c;
    endfunction

    initial begin
        int L, L2, exp_L, w0;

        fifo_wr        = 4'd0;
        reset          = 1'b0;
        bus.en         = 1'b0;
        bus.baud_div   = 16'd4;
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;
        bus.two_stop   = 1'b0;

        // Reset state
        step(3);
        chk("rst_tx",    bus.tx,      1);
        chk("rst_shift", bus.shift,   0);
        chk("rst_busy",  bus.busy,    0);
        chk("rst_done",  bus.tx_done, 0);
        reset = 1'b1;
        step(2);

        // Basic 8N1 frame, div=4, 0xA5
        bus.en = 1'b1;
        exp_L = cyc_n;
        push(8'hA5);
        wait_shift("basic", 20, L);
        chk("basic_latency", L, exp_L);
        check_frame("basic", L, 8'hA5, 4, 0, 0, 0);
        chk("basic_busy_cycles", count_field(L - 2, L + 50 < cyc_n ? L + 50 : cyc_n, 1), 41);
        step(8);
        chk("basic_busy_cycles", count_field(L - 2, L + 48, 1), 41);
        chk("basic_one_shift", count_field(L - 2, L + 48, 0), 1);

        // Parity: even, odd, odd with two stop bits, div=2
        bus.baud_div  = 16'd2;
        bus.parity_en = 1'b1;
        push(8'hA5);
        wait_shift("par_even", 20, L);
        check_frame("par_even", L, 8'hA5, 2, 1, 0, 0);
        chk("par_even_bit", hist[L+19].tx, 0);

        bus.parity_odd = 1'b1;
        push(8'hA5);
        wait_shift("par_odd", 20, L);
        check_frame("par_odd", L, 8'hA5, 2, 1, 1, 0);
        chk("par_odd_bit", hist[L+19].tx, 1);

        bus.two_stop = 1'b1;
        push(8'hA5);
        wait_shift("par_2stop", 20, L);
        check_frame("par_2stop", L, 8'hA5, 2, 1, 1, 1);
        chk("par_2stop_last_busy", hist[L+24].busy, 1);
        chk("par_2stop_done",      hist[L+25].done, 1);
        chk("par_2stop_idle",      hist[L+25].busy, 0);

        // Back-to-back, div=4, 8N1
        bus.baud_div   = 16'd4;
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;
        bus.two_stop   = 1'b0;
        exp_L = cyc_n;
        push(8'h24);
        push(8'h32);
        push(8'h63);
        wait_shift("b2b", 20, L);
        chk("b2b_latency", L, exp_L);
        check_frame("b2b0", L,      8'h24, 4, 0, 0, 0);
        chk("b2b_done_at_load1", hist[L+41].done, 1);
        check_frame("b2b1", L + 41, 8'h32, 4, 0, 0, 0);
        chk("b2b_done_at_load2", hist[L+82].done, 1);
        check_frame("b2b2", L + 82, 8'h63, 4, 0, 0, 0);
        chk("b2b_idle_after", hist[L+124].busy, 0);

        // Gating: enabled but FIFO empty
        w0 = cyc_n;
        step(50);
        chk("empty_no_shift", count_field(w0, cyc_n, 0), 0);
        chk("empty_no_busy",  count_field(w0, cyc_n, 1), 0);
        chk("empty_tx_high",  count_field(w0, cyc_n, 2), 0);

        // Gating: data present but disabled
        bus.en = 1'b0;
        push(8'h5A);
        w0 = cyc_n;
        step(50);
        chk("dis_no_shift", count_field(w0, cyc_n, 0), 0);
        chk("dis_no_busy",  count_field(w0, cyc_n, 1), 0);

        bus.en = 1'b1;
        exp_L = cyc_n;
        wait_shift("en_rise", 20, L);
        chk("en_rise_latency", L, exp_L);
        step(5);
        bus.en = 1'b0;
        push(8'hC3);
        check_frame("en_drop", L, 8'h5A, 4, 0, 0, 0);
        step(60);
        chk("en_drop_no_pop", count_field(L + 1, cyc_n, 0), 0);
        chk("en_drop_fifo_kept", bus.txfe, 0);

        // Divisor captured at LOAD only
        bus.en = 1'b1;
        exp_L = cyc_n;
        wait_shift("div_chg", 20, L);
        chk("div_chg_latency", L, exp_L);
        step(3);
        bus.baud_div = 16'd8;
        push(8'h81);
        check_frame("div_old", L, 8'hC3, 4, 0, 0, 0);
        check_frame("div_new", L + 41, 8'h81, 8, 0, 0, 0);
        bus.baud_div = 16'd4;

        // Asynchronous reset during data bit 3
        push(8'hF0);
        wait_shift("rst_mid", 20, L);
        step(18);
        chk("rst_mid_pre_tx", hist[L+17].tx, 0);
        chk("rst_mid_pre_busy", hist[L+17].busy, 1);
        reset = 1'b0;
        #1;
        chk("rst_mid_tx",    bus.tx,      1);
        chk("rst_mid_busy",  bus.busy,    0);
        chk("rst_mid_shift", bus.shift,   0);
        chk("rst_mid_done",  bus.tx_done, 0);
        push(8'h3C);
        step(3);
        reset = 1'b1;
        exp_L = cyc_n;
        wait_shift("rst_restart", 20, L2);
        chk("rst_restart_latency", L2, exp_L);
        check_frame("rst_restart", L2, 8'h3C, 4, 0, 0, 0);

        // Divisor 0 behaves as 1
        bus.baud_div = 16'd0;
        push(8'h55);
        wait_shift("div0", 20, L);
        check_frame("div0", L, 8'h55, 0, 0, 0, 0);
        chk("div0_done_at_11", hist[L+11].done, 1);
        step(5);

        chk("total_shifts",    shift_cnt,  13);
        chk("total_done",      done_cnt,   12);
        chk("pop_while_empty", empty_pops, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-side sequencer for the UART. Sits between the transmit FIFO (`tx_fifo`) and the serial output pin. When enabled and the FIFO is not empty, it pops one byte per frame and serializes it: start bit, data LSB-first, optional parity, stop bit(s). Bit timing comes from a programmable clock divider.

## Interface

Parameters:
- `DATA_BITS`, 8: data bits per frame; must be ≤ 8.
- `DIV_WIDTH`, 16: width of the baud divisor.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  transmit enable; new frames start only while high.
- `baud_div`  in  DIV_WIDTH  clock cycles per bit; 0 is treated as 1.
- `parity_en`  in  1  insert a parity bit after the data bits.
- `parity_odd`  in  1  1 = odd parity, 0 = even; ignored when `parity_en`=0.
- `two_stop`  in  1  1 = two stop bits, 0 = one.
- `txfe`  in  1  FIFO empty flag from `tx_fifo`.
- `fifo_data`  in  8  FIFO head byte; valid whenever `txfe`=0.
- `shift`  out  1  one-cycle pop strobe to `tx_fifo`.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high in any state other than IDLE.
- `tx_done`  out  1  one-cycle pulse when a frame's last stop bit completes.

## Operation

- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- **IDLE:** `tx`=1.
  - If `en`=1 and `txfe`=0, go to LOAD.
- **LOAD:** lasts exactly one cycle.
  - `shift`=1 (Moore output) and `tx`=1.
  - Capture `fifo_data[DATA_BITS-1:0]` into the shift register.
  - Capture `baud_div` (0→1), `parity_en`, `parity_odd` and `two_stop` into frame registers.
  - Clear the bit-period counter and bit index, then go to START.
- **START:** `tx`=0 for one bit period, then go to DATA.
- **DATA:** `tx` = shift-register bit 0; the register shifts right at the end of each period.
  - After DATA_BITS periods, go to PARITY if the captured `parity_en`=1, else STOP.
- **PARITY:** `tx` = XOR of the captured data bits, XOR the captured `parity_odd`, for one period.
- **STOP:** `tx`=1 for one period (two periods if the captured `two_stop`=1).
  - At the end, `tx_done` pulses for one cycle.
  - Then go to LOAD if `en`=1 and `txfe`=0 at that cycle; otherwise go to IDLE.
- **Bit period:** a counter runs 0..div-1, using the captured divisor. The period ends on the cycle where count = div-1.
- Changes to `baud_div`, `parity_*` or `two_stop` during a frame have no effect until the next LOAD.
- Dropping `en` mid-frame does not abort the frame. The current frame completes; no further pops occur.
- `txfe` is sampled only in IDLE and at the end of STOP. `fifo_data` is sampled only in LOAD.
- `shift` is never asserted when `txfe`=1. Exactly one `shift` occurs per frame.
- `busy`=1 in LOAD, START, DATA, PARITY and STOP.

## Timing

- **Reset (`reset`=0, asynchronous):**
  - State → IDLE.
  - `tx`=1, `shift`=0, `busy`=0, `tx_done`=0.
  - Counters and shift register cleared.
  - Reset mid-frame aborts the frame immediately; the popped byte is lost.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- **Start-up latency:** `en`&&!`txfe` sampled high in IDLE at edge k gives:
  - LOAD (`shift`=1) during cycle k+1.
  - START (`tx`=0) beginning at cycle k+2.
- **Frame length from start of START:** (1 + DATA_BITS + P + S) × div cycles, where P ∈ {0,1} and S ∈ {1,2}.
- **Back-to-back frames:** successive `shift` pulses are exactly 1 + (1 + DATA_BITS + P + S) × div cycles apart. The gap is the LOAD cycle, during which `tx` stays high.
- **Pulse placement:**
  - `tx_done` is high during the cycle immediately following the final stop-bit cycle, i.e. the first cycle of LOAD/IDLE.
  - `busy` falls in that same cycle only when the next state is IDLE.
- **FIFO at end of STOP:**
  - FIFO becomes non-empty during a frame: it is picked up at the end of STOP, with no extra idle cycle.
  - FIFO empty at end of STOP: go to IDLE. A later push is picked up the cycle after `txfe` falls.

## Test plan

- **Basic frame:** div=4, 8N1, FIFO holds 0xA5.
  - `shift` for 1 cycle.
  - `tx` = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles.
  - `tx_done` pulses once; `busy` high for 41 cycles.
- **Parity:** 0xA5, div=2, `parity_en`=1.
  - Even parity: parity bit = 0.
  - Odd parity: parity bit = 1.
  - With `two_stop`=1: stop = 4 cycles high; frame = 24 cycles after LOAD.
- **Back-to-back:** FIFO holds 0x24, 0x32, 0x63; div=4, 8N1.
  - Three `shift` pulses, 41 cycles apart.
  - Three `tx_done` pulses.
  - `busy` stays high continuously until the third stop bit ends.
- **Gating and config capture:**
  - `txfe`=1 with `en`=1: `shift`, `busy` and `tx` stay 0, 0, 1 indefinitely.
  - `en`=0 with FIFO non-empty: no `shift`.
  - `en` dropped mid-frame: the frame finishes and there is no second pop.
  - Change `baud_div` 4→8 mid-frame: the current frame stays at 4 cycles/bit; the next frame uses 8.
- **Reset mid-DATA:** assert `reset`=0 asynchronously between clock edges during bit 3.
  - `tx`=1 and `busy`=0 without waiting for a clock edge.
  - After release with FIFO non-empty, a new frame starts with a fresh `shift`.
- **Divisor edge:** `baud_div`=0 behaves identically to 1: 10-cycle 8N1 frame, `tx` toggling per cycle for 0x55.
